// File: rtl/counter_pkg.sv
// Shared definitions for the SequentialLogic counter family (up_counter, down_counter).
package counter_pkg;

  // Default counter width shared by the up and down counters
  localparam int DEFAULT_WIDTH = 8;

  // Down-counter control states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } counterState_e;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter/timer.
// It stops at zero (EXPIRED) or reloads from the stored value at terminal count.
// Every output comes straight from a flop.
module down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  counterState_e    state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state logic: load beats everything; otherwise only RUN with enable moves the count
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      state_d  = (load_value != '0) ? RUN : IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (enable) begin
            if (count_q == WIDTH'(1)) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = EXPIRED;
              end
            end else if (count_q != '0) begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        EXPIRED: begin
          count_d = '0;
        end
        IDLE: begin
          count_d = count_q;
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == EXPIRED);
  end

  // State, count, reload value and status flags, cleared immediately by async reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign out  = count_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: an 8-bit instance and a 4-bit instance.
// The stimulus pushes the expected post-edge outputs into a queue.
// A monitor pops one entry after each rising edge and compares it.
module tb_down_counter;

  typedef struct {
    bit         narrow;
    logic [7:0] expOut;
    logic       expTc;
    logic       expBusy;
    logic       expDone;
    string      name;
  } expect_t;

  logic       clk;
  logic       reset;

  logic       load;
  logic [7:0] loadValue;
  logic       enable;
  logic       autoReload;
  logic [7:0] outW;
  logic       tcW;
  logic       busyW;
  logic       doneW;

  logic       loadN;
  logic [3:0] loadValueN;
  logic       enableN;
  logic       autoReloadN;
  logic [3:0] outN;
  logic       tcN;
  logic       busyN;
  logic       doneN;

  expect_t    scoreboard[$];
  int         vectorCount;
  int         missCount;

  down_counter #(.WIDTH(8)) dutWide (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_value (loadValue),
    .enable     (enable),
    .auto_reload(autoReload),
    .out        (outW),
    .tc         (tcW),
    .busy       (busyW),
    .done       (doneW)
  );

  down_counter #(.WIDTH(4)) dutNarrow (
    .clk        (clk),
    .reset      (reset),
    .load       (loadN),
    .load_value (loadValueN),
    .enable     (enableN),
    .auto_reload(autoReloadN),
    .out        (outN),
    .tc         (tcN),
    .busy       (busyN),
    .done       (doneN)
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one instance's outputs against an expected tuple and tallies the result
  task automatic checkOutput(input bit narrow, input logic [7:0] eOut, input logic eTc,
                             input logic eBusy, input logic eDone, input string name);
    logic [7:0] aOut;
    logic       aTc, aBusy, aDone;
    if (narrow) begin
      aOut  = {4'b0000, outN};
      aTc   = tcN;
      aBusy = busyN;
      aDone = doneN;
    end else begin
      aOut  = outW;
      aTc   = tcW;
      aBusy = busyW;
      aDone = doneW;
    end
    vectorCount++;
    if (aOut !== eOut || aTc !== eTc || aBusy !== eBusy || aDone !== eDone) begin
      missCount++;
      $display("[TB] FAIL %s: got out=%0d tc=%b busy=%b done=%b, expected out=%0d tc=%b busy=%b done=%b",
               name, aOut, aTc, aBusy, aDone, eOut, eTc, eBusy, eDone);
    end
  endtask

  // Drives one cycle of wide-instance inputs and queues the outputs expected after the next edge
  task automatic applyStimulus(input logic ld, input logic [7:0] lv, input logic en,
                               input logic ar, input logic [7:0] eOut, input logic eTc,
                               input logic eBusy, input logic eDone, input string name);
    expect_t e;
    @(negedge clk);
    load       = ld;
    loadValue  = lv;
    enable     = en;
    autoReload = ar;
    e.narrow  = 1'b0;
    e.expOut  = eOut;
    e.expTc   = eTc;
    e.expBusy = eBusy;
    e.expDone = eDone;
    e.name    = name;
    scoreboard.push_back(e);
  endtask

  // Same as applyStimulus but for the 4-bit instance
  task automatic applyStimulusNarrow(input logic ld, input logic [3:0] lv, input logic en,
                                     input logic [3:0] eOut, input logic eTc,
                                     input logic eBusy, input logic eDone, input string name);
    expect_t e;
    @(negedge clk);
    loadN       = ld;
    loadValueN  = lv;
    enableN     = en;
    autoReloadN = 1'b0;
    e.narrow  = 1'b1;
    e.expOut  = {4'b0000, eOut};
    e.expTc   = eTc;
    e.expBusy = eBusy;
    e.expDone = eDone;
    e.name    = name;
    scoreboard.push_back(e);
  endtask

  // Monitor: one scoreboard entry is consumed shortly after each rising edge
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput(e.narrow, e.expOut, e.expTc, e.expBusy, e.expDone, e.name);
      end
    end
  end

  // Directed stimulus sequence
  initial begin
    int waitCycles;
    vectorCount = 0;
    missCount   = 0;
    reset       = 1'b1;
    load        = 1'b0;
    loadValue   = '0;
    enable      = 1'b0;
    autoReload  = 1'b0;
    loadN       = 1'b0;
    loadValueN  = '0;
    enableN     = 1'b0;
    autoReloadN = 1'b0;

    #2;
    checkOutput(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "resetWide");
    checkOutput(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "resetNarrow");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Enable with no load leaves IDLE untouched
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "idleEnable");

    // Reset in the middle of a count
    applyStimulus(1'b1, 8'd5, 1'b0, 1'b0, 8'd5, 1'b0, 1'b1, 1'b0, "midLoad5");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, "midDec1");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "midDec2");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "asyncReset");
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;

    // One-shot from 3, then saturate at zero
    applyStimulus(1'b1, 8'd3, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "oneLoad3");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "oneOut2");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "oneOut1");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "oneTc");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, "oneSaturate");
    end

    // Pause pattern from 4
    applyStimulus(1'b1, 8'd4, 1'b0, 1'b0, 8'd4, 1'b0, 1'b1, 1'b0, "pauseLoad4");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "pauseOut3");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "pauseHoldA");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, "pauseHoldB");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd2, 1'b0, 1'b1, 1'b0, "pauseOut2");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "pauseOut1");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, "pauseTc");

    // Auto-reload with a period of 2
    applyStimulus(1'b1, 8'd2, 1'b1, 1'b1, 8'd2, 1'b0, 1'b1, 1'b0, "arLoad2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b1, 1'b0, "arOut1");
      applyStimulus(1'b0, 8'd0, 1'b1, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, "arReloadTc");
    end

    // A load on the terminal cycle wins, then a load of zero returns to IDLE
    applyStimulus(1'b1, 8'd1, 1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 1'b0, "colLoad1");
    applyStimulus(1'b1, 8'd9, 1'b1, 1'b0, 8'd9, 1'b0, 1'b1, 1'b0, "colLoad9");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd8, 1'b0, 1'b1, 1'b0, "colOut8");
    applyStimulus(1'b1, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "colLoad0");
    applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "idleAfterLoad0");
    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "wideQuiet");

    // 4-bit instance: load 15, terminal count after exactly 15 enabled edges
    applyStimulusNarrow(1'b1, 4'd15, 1'b1, 4'd15, 1'b0, 1'b1, 1'b0, "narrowLoad15");
    for (int i = 1; i <= 15; i++) begin
      applyStimulusNarrow(1'b0, 4'd0, 1'b1, 4'(15 - i), (i == 15), (i != 15), (i == 15),
                          "narrowCount");
    end
    applyStimulusNarrow(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, "narrowNoWrap");

    @(negedge clk);
    loadN   = 1'b0;
    enableN = 1'b0;
    waitCycles = 0;
    while (scoreboard.size() > 0 && waitCycles < 20) begin
      @(posedge clk);
      waitCycles++;
    end
    #2;
    if (scoreboard.size() > 0) begin
      missCount++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", scoreboard.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
